// File: rtl/iir_stim_gen.sv
// iir_stim_gen: stimulus source and result capture for an HLS-style IIR filter core.
// Streams impulse, step, square or noise samples over an ap_start/ap_ready handshake.
// It allows up to 15 samples in flight and captures each ap_done/ap_return pair.
// Optional feature macro: IIR_STIM_LFSR_EN (mode 3 = 20-bit LFSR noise; otherwise mode 3 = 0).
// Ports:
//   ap_clk, ap_rst             clock, asynchronous active-high reset
//   enable, mode, period,      stream request and waveform configuration
//   amplitude                  (latched on IDLE->RUN)
//   ap_start, x, ap_ready      sample handshake to the filter core
//   ap_done, ap_return         result from the filter core
//   y_data, y_valid, y_count   captured result, one-cycle strobe, result counter
//   busy                       high whenever the FSM is not IDLE
module iir_stim_gen #(
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned PERIOD_W = 10
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DATA_W-1:0]   amplitude,
    output logic                ap_start,
    output logic [DATA_W-1:0]   x,
    input  logic                ap_ready,
    input  logic                ap_done,
    input  logic [DATA_W-1:0]   ap_return,
    output logic [DATA_W-1:0]   y_data,
    output logic                y_valid,
    output logic [15:0]         y_count,
    output logic                busy
);

    localparam int unsigned OUT_W = 4;
    localparam logic [OUT_W-1:0] OUT_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [PERIOD_W-1:0] phase_nxt, per_in;
    logic [DATA_W-1:0]   amp_q, amp_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_data_q, y_data_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                y_valid_q, y_valid_d;
    logic [15:0]         y_count_q, y_count_d;
    logic                accept;

`ifdef IIR_STIM_LFSR_EN
    localparam int unsigned LFSR_W = 20;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 20'h00001;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;

    // Fibonacci LFSR, taps 20 and 17
    assign lfsr_adv = {lfsr_q[LFSR_W-2:0], lfsr_q[19] ^ lfsr_q[16]};
`endif

    // Deterministic waveform sample for a given phase; mode 3 handled by the caller
    function automatic logic [DATA_W-1:0] shape(input logic [1:0]          m,
                                                input logic [PERIOD_W-1:0] ph,
                                                input logic [PERIOD_W-1:0] p,
                                                input logic [DATA_W-1:0]   amp);
        logic [DATA_W-1:0] r;
        r = '0;
        case (m)
            2'd0:    r = (ph == PERIOD_W'(0)) ? amp : '0;
            2'd1:    r = amp;
            2'd2:    r = (ph < (p >> 1)) ? amp : (DATA_W'(0) - amp);
            default: r = '0;
        endcase
        return r;
    endfunction

    // A zero period behaves as a period of one
    assign per_in    = (period == PERIOD_W'(0)) ? PERIOD_W'(1) : period;
    assign phase_nxt = (phase_q == (per_q - PERIOD_W'(1))) ? PERIOD_W'(0)
                                                           : (phase_q + PERIOD_W'(1));
    assign ap_start  = (state_q == RUN) && (out_q != OUT_MAX);
    assign accept    = ap_start && ap_ready;

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        per_d     = per_q;
        amp_d     = amp_q;
        phase_d   = phase_q;
        x_d       = x_q;
        out_d     = out_q;
        y_data_d  = y_data_q;
        y_count_d = y_count_q;
        y_valid_d = ap_done;
`ifdef IIR_STIM_LFSR_EN
        lfsr_d    = lfsr_q;
`endif

        // Results are captured in every state
        if (ap_done) begin
            y_data_d  = ap_return;
            y_count_d = y_count_q + 16'd1;
        end

        // In-flight count; a done with nothing outstanding is ignored
        if (accept && !ap_done) begin
            out_d = out_q + 4'd1;
        end else if (!accept && ap_done && (out_q != '0)) begin
            out_d = out_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                x_d = '0;
                if (enable) begin
                    state_d = RUN;
                    mode_d  = mode;
                    per_d   = per_in;
                    amp_d   = amplitude;
                    phase_d = '0;
                    out_d   = '0;
`ifdef IIR_STIM_LFSR_EN
                    lfsr_d  = LFSR_SEED;
                    x_d     = (mode == 2'd3) ? DATA_W'($signed(LFSR_SEED))
                                             : shape(mode, PERIOD_W'(0), per_in, amplitude);
`else
                    x_d     = shape(mode, PERIOD_W'(0), per_in, amplitude);
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    phase_d = phase_nxt;
`ifdef IIR_STIM_LFSR_EN
                    lfsr_d  = lfsr_adv;
                    x_d     = (mode_q == 2'd3) ? DATA_W'($signed(lfsr_adv))
                                               : shape(mode_q, phase_nxt, per_q, amp_q);
`else
                    x_d     = shape(mode_q, phase_nxt, per_q, amp_q);
`endif
                end
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = IDLE;
                    x_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            per_q     <= '0;
            amp_q     <= '0;
            phase_q   <= '0;
            x_q       <= '0;
            out_q     <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_count_q <= '0;
`ifdef IIR_STIM_LFSR_EN
            lfsr_q    <= LFSR_SEED;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            per_q     <= per_d;
            amp_q     <= amp_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            out_q     <= out_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_count_q <= y_count_d;
`ifdef IIR_STIM_LFSR_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign x       = x_q;
    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_count = y_count_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/iir_stim_gen.md
IIR_STIM_GEN -- requirements
Module: iir_stim_gen

Interface
REQ-001 Parameter DATA_W, default 20, sample width (signed two's complement) of x, amplitude and ap_return.
REQ-002 Parameter PERIOD_W, default 10, width of the period input and the phase counter.
REQ-003 ap_clk  in  1  single clock; all logic is rising-edge.
REQ-004 ap_rst  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  level; high requests streaming, low requests stop.
REQ-006 mode  in  2  0=impulse, 1=step, 2=square, 3=noise/zero (see REQ-030).
REQ-007 period  in  PERIOD_W  samples per stimulus cycle; 0 is treated as 1.
REQ-008 amplitude  in  DATA_W  signed stimulus amplitude.
REQ-009 ap_start  out  1  to filter core; sample request.
REQ-010 x  out  DATA_W  to filter core; current sample.
REQ-011 ap_ready  in  1  from filter core; sample accepted when ap_start&&ap_ready.
REQ-012 ap_done  in  1  from filter core; ap_return valid.
REQ-013 ap_return  in  DATA_W  from filter core; filter output.
REQ-014 y_data  out  DATA_W  captured filter output; y_valid  out  1  one-cycle strobe.
REQ-015 y_count  out  16  captured-result counter; busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when outstanding=0; DRAIN->RUN not allowed.
REQ-017 mode, period, amplitude are latched on the IDLE->RUN transition only; input changes during RUN/DRAIN are ignored.
REQ-018 On IDLE->RUN: phase<=0, outstanding<=0, x<=first sample for phase 0.
REQ-019 ap_start = (state==RUN) && (outstanding<15), combinational from registers.
REQ-020 Acceptance = ap_start&&ap_ready; on acceptance phase<=(phase==P-1)?0:phase+1, where P is the latched period (1 if 0), and x<=sample for the new phase, valid the next cycle.
REQ-021 x holds its value while ap_start is high without ap_ready.
REQ-022 Impulse: x=amplitude at phase 0, else 0.
REQ-023 Step: x=amplitude at every phase.
REQ-024 Square: x=amplitude for phase<(P>>1), else -amplitude (two's complement, wrapping); P=1 gives -amplitude at every phase.
REQ-025 outstanding (4 bits) +1 on acceptance, -1 on ap_done, unchanged when both occur in the same cycle; ap_done with outstanding=0 is ignored (no underflow).
REQ-026 On ap_done: y_data<=ap_return, y_valid=1 on the next cycle for exactly one cycle, y_count<=y_count+1, wrapping at 0xFFFF.
REQ-027 ap_done is captured in every state, including IDLE.
REQ-028 In IDLE, x=0.

Reset
REQ-029 ap_rst asserted at any time, including mid-RUN or mid-DRAIN, forces: state=IDLE, ap_start=0, x=0, phase=0, outstanding=0, y_data=0, y_valid=0, y_count=0, busy=0, LFSR=20'h00001.

Configuration
REQ-030 Macro IIR_STIM_LFSR_EN defined: mode 3 outputs a 20-bit Fibonacci LFSR (taps 20,17; seed 20'h00001 reloaded on IDLE->RUN) advanced on each acceptance; x={LFSR} when DATA_W=20, LSB-truncated or sign-extended otherwise.
REQ-031 Macro IIR_STIM_LFSR_EN undefined: mode 3 outputs x=0; no LFSR logic is present.

Verification
REQ-032 Impulse, period=4, amplitude=20'h10000, ap_ready=1 -> x sequence 10000,0,0,0,10000,...; one acceptance per cycle.
REQ-033 Square, period=4, amplitude=20'h10000 -> x sequence 10000,10000,F0000,F0000 repeating; period=0 in impulse mode -> x=10000 on every sample.
REQ-034 Core stub with 3-cycle ap_done latency; drop enable after 10 acceptances -> state DRAIN, ap_start=0, exactly 10 y_valid strobes, y_count=10, then IDLE with busy=0.
REQ-035 ap_done never asserted -> ap_start falls after 15 acceptances; a single ap_done then re-enables exactly one more acceptance; simultaneous acceptance and ap_done leave outstanding unchanged.
REQ-036 ap_rst pulsed mid-RUN with outstanding=5 -> all outputs at reset values in the same cycle (asynchronous); restart begins at phase 0.
REQ-037 With IIR_STIM_LFSR_EN, mode 3 -> first x values 00001,00002,00004 ...; without it -> x=0 throughout.
